// File: rtl/pcs_traffic_gen_pkg.sv
// pcs_tgen_pkg: shared types, LFSR tap mask and the lane-word packer for the
// PCS traffic generator.
package pcs_tgen_pkg;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_e;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Upper bounds for the generic packer; callers cast the result down to
    // their own NLANE*LW width.
    localparam int MAX_LW    = 32;
    localparam int MAX_LANES = 64;
    localparam int MAX_DW    = MAX_LW * MAX_LANES;

    // Lane i carries (seq + i) mod 2^lw, placed at bits i*lw +: lw.
    function automatic logic [MAX_DW-1:0] lane_pack(input logic [MAX_LW-1:0] seq,
                                                    input int nlane,
                                                    input int lw);
        logic [MAX_DW-1:0] w;
        logic [MAX_LW-1:0] mask;
        logic [MAX_LW-1:0] v;
        w    = '0;
        mask = (lw >= MAX_LW) ? '1 : ((MAX_LW'(1) << lw) - MAX_LW'(1));
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < nlane) begin
                v = (seq + MAX_LW'(i)) & mask;
                w = w | (MAX_DW'(v) << (i * lw));
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pcs_traffic_gen_if.sv
// pcs_tgen_if: control inputs and word outputs of the traffic generator.
// master = generator side, slave = bench / downstream side.
interface pcs_tgen_if #(
    parameter int NLANE = 16,
    parameter int LW    = 12
);
    localparam int DATA_W = NLANE * LW;

    logic              enable;
    logic              ready;
    logic              send_ts;
    logic [9:0]        thresh_hi;
    logic [9:0]        thresh_lo;
    logic [DATA_W-1:0] data;
    logic              txen;
    logic [31:0]       words_sent;

    modport master (
        input  enable, ready, send_ts, thresh_hi, thresh_lo,
        output data, txen, words_sent
    );

    modport slave (
        output enable, ready, send_ts, thresh_hi, thresh_lo,
        input  data, txen, words_sent
    );
endinterface

// File: rtl/pcs_traffic_gen_lfsr.sv
// pcs_tgen_lfsr: 16-bit Galois LFSR used as the throttle's random source.
// Loads SEED on reset, advances one step per cycle while step_i is high.
// Only the low 10 bits are consumed downstream, so only those are exported.
module pcs_tgen_lfsr
    import pcs_tgen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       step_i,
    output logic [9:0] rnd_o
);

    logic [15:0] lfsr_q, lfsr_d;

    // Next state: shift right, fold the dropped bit back through the taps
    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    // State register with synchronous seed load
    always_ff @(posedge clk) begin
        if (!reset_n) lfsr_q <= SEED;
        else          lfsr_q <= lfsr_d;
    end

    assign rnd_o = lfsr_q[9:0];

endmodule

// File: rtl/pcs_traffic_gen.sv
// pcs_traffic_gen: test-traffic source for the PCS fast-side TX.
// Emits NLANE x LW incrementing-lane words, gated by ready and an LFSR
// throttle with a two-phase (high/low rate) schedule.
// Optional feature macro: PCS_TGEN_TS_EN -- when defined, send_ts words carry
// a free-running cycle timestamp in the low lanes.
module pcs_traffic_gen
    import pcs_tgen_pkg::*;
#(
    parameter int          NLANE     = 16,
    parameter int          LW        = 12,
    parameter int          TS_W      = 32,
    parameter int          PHASE_LEN = 40000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic      clk,
    input  logic      reset_n,
    pcs_tgen_if.master bus
);

    localparam int DATA_W = NLANE * LW;
    localparam int PH_W   = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

    // Elaboration-time configuration checks
    if (TS_W < 1 || TS_W > DATA_W) begin : g_bad_ts_w
        $error("pcs_traffic_gen: TS_W out of range");
    end
    if (PHASE_LEN < 1) begin : g_bad_phase_len
        $error("pcs_traffic_gen: PHASE_LEN must be >= 1");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("pcs_traffic_gen: LFSR_SEED must be nonzero");
    end

    logic [9:0]        rnd;
    logic [9:0]        thr;
    logic              allow;
    logic              pop;
    logic [LW-1:0]     seq_q, seq_d;
    logic [31:0]       sent_q, sent_d;
    phase_e            phase_q, phase_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [DATA_W-1:0] seq_word;
    logic [DATA_W-1:0] word;

    pcs_tgen_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .step_i  (bus.enable),
        .rnd_o   (rnd)
    );

    // Throttle decision and zero-latency handshake
    always_comb begin
        thr   = (phase_q == PH_HI) ? bus.thresh_hi : bus.thresh_lo;
        allow = (rnd < thr);
        pop   = reset_n & bus.enable & bus.ready & (bus.send_ts | allow);
    end

    assign seq_word = DATA_W'(lane_pack(MAX_LW'(seq_q), NLANE, LW));

`ifdef PCS_TGEN_TS_EN
    // Whole lanes touched by the timestamp; their bits above TS_W read as 0.
    localparam int                TS_BITS = ((TS_W + LW - 1) / LW) * LW;
    localparam logic [DATA_W-1:0] TS_MASK = DATA_W'({TS_BITS{1'b1}});

    logic [TS_W-1:0] ts_cnt_q;

    // Free-running cycle counter, independent of enable
    always_ff @(posedge clk) begin
        if (!reset_n) ts_cnt_q <= '0;
        else          ts_cnt_q <= ts_cnt_q + TS_W'(1);
    end

    // Overlay the timestamp onto the low lanes in timestamp mode
    always_comb begin
        word = seq_word;
        if (bus.send_ts) begin
            word = (seq_word & ~TS_MASK) | DATA_W'(ts_cnt_q);
        end
    end
`else
    assign word = seq_word;
`endif

    // Sequence and sent-count advance only on an accepted word
    always_comb begin
        seq_d  = seq_q;
        sent_d = sent_q;
        if (pop) begin
            seq_d  = seq_q + LW'(NLANE);
            sent_d = sent_q + 32'd1;
        end
    end

    // Sequence / count registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seq_q  <= '0;
            sent_q <= '0;
        end else begin
            seq_q  <= seq_d;
            sent_q <= sent_d;
        end
    end

    // Phase FSM next state: toggles after PHASE_LEN accepted words
    always_comb begin
        phase_d  = phase_q;
        ph_cnt_d = ph_cnt_q;
        if (pop) begin
            if (ph_cnt_q == PH_W'(PHASE_LEN - 1)) begin
                ph_cnt_d = '0;
                phase_d  = (phase_q == PH_HI) ? PH_LO : PH_HI;
            end else begin
                ph_cnt_d = ph_cnt_q + PH_W'(1);
            end
        end
    end

    // Phase FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q  <= PH_HI;
            ph_cnt_q <= '0;
        end else begin
            phase_q  <= phase_d;
            ph_cnt_q <= ph_cnt_d;
        end
    end

    assign bus.txen       = pop;
    assign bus.data       = pop ? word : '0;
    assign bus.words_sent = sent_q;

endmodule
